// File: rtl/fx1_pipe_if.sv
// rtl/fx1_pipe_if.sv - issue, forwarding and writeback bundle for the fx1 pipe
interface fx1_pipe_if #(
    parameter int RT_W  = 7,
    parameter int CNT_W = 16
);
    logic              issue_valid;
    logic [0:2]        op;
    logic [0:127]      ra;
    logic [0:127]      rb;
    logic [0:RT_W-1]   rt_addr;
    logic              flush;

    logic              fwd_valid;
    logic [0:RT_W-1]   fwd_rt;

    logic              wb_valid;
    logic [0:RT_W-1]   wb_rt;
    logic [0:127]      wb_data;
    logic [0:CNT_W-1]  retired_cnt;

    modport master (
        output issue_valid, op, ra, rb, rt_addr, flush,
        input  fwd_valid, fwd_rt, wb_valid, wb_rt, wb_data, retired_cnt
    );

    modport slave (
        input  issue_valid, op, ra, rb, rt_addr, flush,
        output fwd_valid, fwd_rt, wb_valid, wb_rt, wb_data, retired_cnt
    );
endinterface

// File: rtl/fx1_pipe.sv
// rtl/fx1_pipe.sv - two-stage 128-bit SIMD fixed-point pipe with flush and retire counter
module fx1_pipe #(
    parameter int RT_W  = 7,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    fx1_pipe_if.slave  bus
);
    localparam logic [0:2] OP_AH   = 3'b000;
    localparam logic [0:2] OP_A    = 3'b001;
    localparam logic [0:2] OP_SFH  = 3'b010;
    localparam logic [0:2] OP_SF   = 3'b011;
    localparam logic [0:2] OP_AND  = 3'b100;
    localparam logic [0:2] OP_OR   = 3'b101;
    localparam logic [0:2] OP_XOR  = 3'b110;
    localparam logic [0:2] OP_CEQH = 3'b111;

    logic              s1_valid;
    logic [0:2]        s1_op;
    logic [0:127]      s1_ra;
    logic [0:127]      s1_rb;
    logic [0:RT_W-1]   s1_rt;

    logic              s2_valid;
    logic [0:RT_W-1]   s2_rt;
    logic [0:127]      s2_data;
    logic [0:CNT_W-1]  cnt;

    logic [0:127]      result;
    logic              s1_load;
    logic              s2_load;

    // flush kills both the same-cycle issue and whatever sits in stage 1
    assign s1_load = bus.issue_valid & ~bus.flush;
    assign s2_load = s1_valid & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_ra    <= '0;
            s1_rb    <= '0;
            s1_rt    <= '0;
        end else begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_op <= bus.op;
                s1_ra <= bus.ra;
                s1_rb <= bus.rb;
                s1_rt <= bus.rt_addr;
            end
        end
    end

    // lane slices are taken per lane so carries and borrows never cross lanes
    always_comb begin
        result = '0;
        case (s1_op)
            OP_AH: begin
                for (int i = 0; i < 8; i++)
                    result[16*i +: 16] = s1_ra[16*i +: 16] + s1_rb[16*i +: 16];
            end
            OP_A: begin
                for (int i = 0; i < 4; i++)
                    result[32*i +: 32] = s1_ra[32*i +: 32] + s1_rb[32*i +: 32];
            end
            OP_SFH: begin
                for (int i = 0; i < 8; i++)
                    result[16*i +: 16] = s1_rb[16*i +: 16] - s1_ra[16*i +: 16];
            end
            OP_SF: begin
                for (int i = 0; i < 4; i++)
                    result[32*i +: 32] = s1_rb[32*i +: 32] - s1_ra[32*i +: 32];
            end
            OP_AND: result = s1_ra & s1_rb;
            OP_OR:  result = s1_ra | s1_rb;
            OP_XOR: result = s1_ra ^ s1_rb;
            OP_CEQH: begin
                for (int i = 0; i < 8; i++)
                    result[16*i +: 16] = (s1_ra[16*i +: 16] == s1_rb[16*i +: 16]) ? 16'hFFFF : 16'h0000;
            end
            default: result = '0;
        endcase
    end

    // writeback data only moves on a valid load so it holds across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_rt    <= '0;
            s2_data  <= '0;
            cnt      <= '0;
        end else begin
            s2_valid <= s2_load;
            if (s2_load) begin
                s2_rt   <= s1_rt;
                s2_data <= result;
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_valid   = s1_valid;
    assign bus.fwd_rt      = s1_rt;
    assign bus.wb_valid    = s2_valid;
    assign bus.wb_rt       = s2_rt;
    assign bus.wb_data     = s2_data;
    assign bus.retired_cnt = cnt;
endmodule

// File: tb/tb_fx1_pipe.sv
// tb/tb_fx1_pipe.sv - directed self-checking bench for fx1_pipe
module tb_fx1_pipe;
    localparam logic [2:0] AH = 3'b000, A = 3'b001, SFH = 3'b010, SF = 3'b011;
    localparam logic [2:0] AND_OP = 3'b100, OR_OP = 3'b101, XOR_OP = 3'b110, CEQH = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    logic [2:0]   b_op [4];
    logic [127:0] b_a  [4];
    logic [127:0] b_b  [4];
    logic [127:0] b_e  [4];

    fx1_pipe_if #(.RT_W(7), .CNT_W(16)) bus ();

    fx1_pipe #(.RT_W(7), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [127:0] a,
                         input logic [127:0] b, input logic [6:0] rt);
        bus.issue_valid = v;
        bus.op          = o;
        bus.ra          = a;
        bus.rb          = b;
        bus.rt_addr     = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input string tag, input logic [2:0] o, input logic [127:0] a,
                        input logic [127:0] b, input logic [6:0] rt, input logic [127:0] exp);
        drive(1'b1, o, a, b, rt);
        tick();
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        tick();
        chk({tag, "_wb_valid"}, 128'(bus.wb_valid), 128'd1);
        chk({tag, "_wb_rt"}, 128'(bus.wb_rt), 128'(rt));
        chk({tag, "_wb_data"}, 128'(bus.wb_data), exp);
    endtask

    initial begin
        b_op[0] = AH;     b_a[0] = {8{16'h8000}};     b_b[0] = {8{16'h8001}};     b_e[0] = {8{16'h0001}};
        b_op[1] = A;      b_a[1] = {4{32'hFFFFFFFF}}; b_b[1] = {4{32'h00000002}}; b_e[1] = {4{32'h00000001}};
        b_op[2] = XOR_OP; b_a[2] = {16{8'hA5}};       b_b[2] = {16{8'hFF}};       b_e[2] = {16{8'h5A}};
        b_op[3] = OR_OP;  b_a[3] = {8{16'h1200}};     b_b[3] = {8{16'h0034}};     b_e[3] = {8{16'h1234}};

        rst_n     = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        #3;
        chk("rst_fwd_valid", 128'(bus.fwd_valid), 128'd0);
        chk("rst_fwd_rt", 128'(bus.fwd_rt), 128'd0);
        chk("rst_wb_valid", 128'(bus.wb_valid), 128'd0);
        chk("rst_wb_rt", 128'(bus.wb_rt), 128'd0);
        chk("rst_wb_data", 128'(bus.wb_data), 128'd0);
        chk("rst_cnt", 128'(bus.retired_cnt), 128'd0);

        tick();
        rst_n = 1'b1;
        drive(1'b1, AH, {8{16'hFFFF}}, {8{16'h0001}}, 7'd5);
        tick();
        chk("ah_fwd_valid", 128'(bus.fwd_valid), 128'd1);
        chk("ah_fwd_rt", 128'(bus.fwd_rt), 128'd5);
        chk("ah_wb_early", 128'(bus.wb_valid), 128'd0);
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        tick();
        chk("ah_wb_valid", 128'(bus.wb_valid), 128'd1);
        chk("ah_wb_rt", 128'(bus.wb_rt), 128'd5);
        chk("ah_wb_data", 128'(bus.wb_data), 128'd0);
        chk("ah_cnt", 128'(bus.retired_cnt), 128'd1);

        exec("sf", SF, {4{32'h00000001}}, {4{32'h00000000}}, 7'd9, {4{32'hFFFFFFFF}});
        exec("ceqh", CEQH, 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444,
             128'h0123_4567_89AB_CDEE_1111_2222_3333_4444, 7'd17,
             128'hFFFF_FFFF_FFFF_0000_FFFF_FFFF_FFFF_FFFF);
        tick();
        chk("hold_wb_valid", 128'(bus.wb_valid), 128'd0);
        chk("hold_wb_data", 128'(bus.wb_data), 128'hFFFF_FFFF_FFFF_0000_FFFF_FFFF_FFFF_FFFF);
        exec("sfh", SFH, {8{16'h0003}}, {8{16'h0001}}, 7'd33, {8{16'hFFFE}});
        exec("and", AND_OP, {8{16'hF0F0}}, {8{16'hFF00}}, 7'd127, {8{16'hF000}});
        chk("cnt_after_singles", 128'(bus.retired_cnt), 128'd5);

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, b_op[k], b_a[k], b_b[k], 7'(k + 1));
            tick();
            if (k > 0) begin
                chk("b2b_wb_valid", 128'(bus.wb_valid), 128'd1);
                chk("b2b_wb_rt", 128'(bus.wb_rt), 128'(k));
                chk("b2b_wb_data", 128'(bus.wb_data), b_e[k-1]);
            end
        end
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        tick();
        chk("b2b_last_valid", 128'(bus.wb_valid), 128'd1);
        chk("b2b_last_rt", 128'(bus.wb_rt), 128'd4);
        chk("b2b_last_data", 128'(bus.wb_data), b_e[3]);
        chk("b2b_cnt", 128'(bus.retired_cnt), 128'd9);

        drive(1'b1, XOR_OP, {16{8'h11}}, {16{8'h22}}, 7'd10);
        tick();
        drive(1'b1, OR_OP, {16{8'h44}}, {16{8'h88}}, 7'd11);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_fwd_valid", 128'(bus.fwd_valid), 128'd0);
        chk("flush_wb_valid", 128'(bus.wb_valid), 128'd0);
        drive(1'b1, AND_OP, {8{16'hF0F0}}, {8{16'hFF00}}, 7'd12);
        tick();
        chk("post_flush_fwd_valid", 128'(bus.fwd_valid), 128'd1);
        chk("post_flush_fwd_rt", 128'(bus.fwd_rt), 128'd12);
        chk("post_flush_wb_early", 128'(bus.wb_valid), 128'd0);
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        tick();
        chk("post_flush_wb_valid", 128'(bus.wb_valid), 128'd1);
        chk("post_flush_wb_rt", 128'(bus.wb_rt), 128'd12);
        chk("post_flush_wb_data", 128'(bus.wb_data), {8{16'hF000}});
        chk("post_flush_cnt", 128'(bus.retired_cnt), 128'd10);
        tick();
        chk("bubble_cnt", 128'(bus.retired_cnt), 128'd10);
        chk("bubble_wb_valid", 128'(bus.wb_valid), 128'd0);

        drive(1'b1, AH, {8{16'h0001}}, {8{16'h0001}}, 7'd20);
        tick();
        drive(1'b1, A, {4{32'h1}}, {4{32'h1}}, 7'd21);
        tick();
        chk("pre_rst_wb_valid", 128'(bus.wb_valid), 128'd1);
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wb_valid", 128'(bus.wb_valid), 128'd0);
        chk("async_rst_fwd_valid", 128'(bus.fwd_valid), 128'd0);
        chk("async_rst_cnt", 128'(bus.retired_cnt), 128'd0);
        chk("async_rst_wb_data", 128'(bus.wb_data), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("after_rst_wb_valid", 128'(bus.wb_valid), 128'd0);
        chk("after_rst_cnt", 128'(bus.retired_cnt), 128'd0);

        drive(1'b1, AND_OP, {8{16'hFFFF}}, {8{16'h00FF}}, 7'd1);
        repeat (65536) tick();
        chk("cnt_all_ones", 128'(bus.retired_cnt), 128'h0000_FFFF);
        drive(1'b0, 3'b000, '0, '0, 7'd0);
        tick();
        chk("cnt_wrap", 128'(bus.retired_cnt), 128'd0);
        tick();
        chk("cnt_idle_after_wrap", 128'(bus.retired_cnt), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fx1_pipe.md
FX1_PIPE -- requirements
Module: fx1_pipe

Interface
REQ-001 Parameter RT_W, default 7, SHALL set the width of the target register address.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the retire counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 issue_valid  input  1  SHALL mark that op/ra/rb/rt_addr carry an instruction this cycle.
REQ-006 op  input  [0:2]  SHALL select the operation: 000 ah, 001 a, 010 sfh, 011 sf, 100 and, 101 or, 110 xor, 111 ceqh.
REQ-007 ra, rb  input  [0:127] each  SHALL carry the source operands; bit 0 is the MSB.
REQ-008 rt_addr  input  [0:RT_W-1]  SHALL carry the target register number.
REQ-009 flush  input  1  SHALL cancel all in-flight and same-cycle instructions.
REQ-010 fwd_valid, fwd_rt  output  1, [0:RT_W-1]  SHALL identify the stage-1 instruction, for hazard checking.
REQ-011 wb_valid, wb_rt, wb_data  output  1, [0:RT_W-1], [0:127]  SHALL present the writeback result.
REQ-012 retired_cnt  output  [0:CNT_W-1]  SHALL count instructions delivered on wb.

Function
REQ-013 Stage 1 SHALL register issue_valid, op, ra, rb and rt_addr on the rising edge following issue.
REQ-014 The result SHALL be computed combinationally from the stage-1 registers and captured into stage 2 on the next rising edge.
REQ-015 Latency SHALL be exactly 2 clocks: an instruction issued before edge N SHALL appear on wb_* after edge N+1.
REQ-016 Throughput SHALL be one instruction per clock, with no stalls and no backpressure.
REQ-017 ah/sfh/ceqh SHALL operate on 8 independent 16-bit lanes ([0:15] ... [112:127]); a/sf SHALL operate on 4 independent 32-bit lanes.
REQ-018 Add and subtract SHALL be modulo the lane width, with no carry or borrow crossing a lane boundary.
REQ-019 sfh/sf SHALL compute rb minus ra per lane.
REQ-020 ceqh SHALL set a lane to 0xFFFF if ra lane equals rb lane, else 0x0000.
REQ-021 and/or/xor SHALL be bitwise across all 128 bits.
REQ-022 fwd_valid/fwd_rt SHALL reflect the stage-1 valid and address registers.
REQ-023 wb_* SHALL reflect the stage-2 registers.
REQ-024 wb_data SHALL hold its last value when wb_valid=0; only wb_valid is cleared.
REQ-025 Flush asserted before edge N SHALL clear the stage-1 and stage-2 valid bits at edge N.
REQ-026 An issue in the same cycle as flush SHALL be dropped.
REQ-027 An issue in the cycle after flush SHALL proceed normally.
REQ-028 retired_cnt SHALL increment by 1 on each edge at which stage-2 valid is loaded as 1.
REQ-029 retired_cnt SHALL wrap from all-ones to 0.
REQ-030 Flushed instructions SHALL NOT be counted.
REQ-031 Stage valid bits SHALL advance every cycle independent of data; an invalid slot SHALL not alter retired_cnt.

Reset
REQ-032 While rst_n=0, all of the following SHALL be 0 immediately, with no clock required: stage-1 and stage-2 valid bits, fwd_valid, fwd_rt, wb_valid, wb_rt, wb_data, retired_cnt.
REQ-033 Reset mid-operation SHALL discard all in-flight instructions; none SHALL appear on wb after release.
REQ-034 The first edge with rst_n=1 SHALL accept an issue normally.

Verification
REQ-035 ah, ra lanes all 0xFFFF, rb lanes all 0x0001, rt=5 -> two clocks later wb_valid=1, wb_rt=5, wb_data all zero (no cross-lane carry), retired_cnt=1.
REQ-036 sf, ra words 0x00000001, rb words 0x00000000 -> wb_data words 0xFFFFFFFF; and ceqh with ra=rb except lane 3 -> wb_data 0xFFFF in every lane except lane 3 = 0x0000.
REQ-037 Back-to-back issue of 4 ops (ah, a, xor, or) on consecutive cycles -> 4 consecutive wb_valid cycles in issue order with correct data; retired_cnt=4.
REQ-038 Issue at cycle 0 and cycle 1, flush asserted in cycle 1 -> neither instruction reaches wb; issue at cycle 2 appears at wb after edge 3; retired_cnt increments once.
REQ-039 rst_n driven low asynchronously while 2 instructions are in flight -> wb_valid, fwd_valid and retired_cnt go to 0 immediately; nothing retires after release.
REQ-040 retired_cnt preloaded to 0xFFFF via 65535 retirements, then 1 more retirement -> retired_cnt=0x0000.
